// File: rtl/sb_obi_wb_bridge.sv
// OBI system-bus master to Wishbone B4 classic bridge for debug SBA.
// One transaction in flight; a bus timeout turns a silent slave into an error.
module sb_obi_wb_bridge #(
  parameter int unsigned AddrWidth     = 30,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] ErrData       = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sb_req_i,
  output logic                 sb_gnt_o,
  input  logic [31:0]          sb_addr_i,
  input  logic                 sb_we_i,
  input  logic [3:0]           sb_be_i,
  input  logic [31:0]          sb_wdata_i,
  output logic                 sb_rvalid_o,
  output logic [31:0]          sb_rdata_o,
  output logic                 sb_err_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [AddrWidth-1:0] wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_w_o,
  input  logic [31:0]          wb_dat_r_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  localparam bit TmoOn = (TimeoutCycles != 0);
  localparam int unsigned CntW =
    TmoOn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
    TmoOn ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic {
    IDLE,
    BUS
  } state_e;

  state_e                 state_q, state_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [AddrWidth-1:0]   adr_q, adr_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            dat_w_q, dat_w_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   tmo;
  logic                   done;
  logic                   bad;
  logic                   unused_addr;

  assign unused_addr = ^sb_addr_i[1:0];

  // A timeout only counts when the slave is silent in that very cycle
  assign tmo  = TmoOn && (cnt_q == CntLast);
  assign done = wb_ack_i | wb_err_i | tmo;
  assign bad  = wb_err_i | (tmo & ~wb_ack_i);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dat_w_d  = dat_w_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sb_gnt_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        sb_gnt_o = sb_req_i & ~rst_i;
        if (sb_req_i) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = sb_we_i;
          adr_d   = sb_addr_i[AddrWidth+1:2];
          sel_d   = sb_be_i;
          dat_w_d = sb_wdata_i;
          cnt_d   = '0;
        end
      end
      BUS: begin
        if (done) begin
          state_d  = IDLE;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = bad;
          if (we_q)     rdata_d = '0;
          else if (bad) rdata_d = ErrData;
          else          rdata_d = wb_dat_r_i;
        end else if (TmoOn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_w_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_w_q  <= dat_w_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_w_o  = dat_w_q;
  assign sb_rvalid_o = rvalid_q;
  assign sb_rdata_o  = rdata_q;
  assign sb_err_o    = err_q;

endmodule

// File: tb/tb_sb_obi_wb_bridge.sv
// Self-checking bench for sb_obi_wb_bridge.
// Expected responses come from a transaction-level model of the bridge.
module tb_sb_obi_wb_bridge;

  localparam int          TO = 8;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sb_req_i;
  logic        sb_gnt_o;
  logic [31:0] sb_addr_i;
  logic        sb_we_i;
  logic [3:0]  sb_be_i;
  logic [31:0] sb_wdata_i;
  logic        sb_rvalid_o;
  logic [31:0] sb_rdata_o;
  logic        sb_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_w_o;
  logic [31:0] wb_dat_r_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  sb_obi_wb_bridge #(
    .AddrWidth    (30),
    .TimeoutCycles(TO),
    .ErrData      (ED)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sb_req_i   (sb_req_i),
    .sb_gnt_o   (sb_gnt_o),
    .sb_addr_i  (sb_addr_i),
    .sb_we_i    (sb_we_i),
    .sb_be_i    (sb_be_i),
    .sb_wdata_i (sb_wdata_i),
    .sb_rvalid_o(sb_rvalid_o),
    .sb_rdata_o (sb_rdata_o),
    .sb_err_o   (sb_err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_w_o (wb_dat_w_o),
    .wb_dat_r_i (wb_dat_r_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  // mode: 0 ack, 1 err, 2 ack+err; wait_n >= TO means the slave never answers
  task automatic run_txn(
    input logic [31:0] addr,
    input logic        we,
    input logic [3:0]  be,
    input logic [31:0] wdata,
    input logic [31:0] sdata,
    input int          wait_n,
    input int          mode,
    input string       name
  );
    int          ncyc;
    int          rv_at;
    int          cyc_cnt;
    int          rv_cnt;
    logic        bad;
    logic        stable;
    logic [31:0] exp_rd;
    logic [29:0] exp_adr;
    logic [31:0] got_rd;
    logic        got_err;
    bad     = (mode != 0) || (wait_n >= TO);
    ncyc    = (wait_n >= TO) ? TO : wait_n + 1;
    exp_rd  = we ? 32'h0 : (bad ? ED : sdata);
    exp_adr = addr[31:2];
    sb_req_i   = 1'b1;
    sb_addr_i  = addr;
    sb_we_i    = we;
    sb_be_i    = be;
    sb_wdata_i = wdata;
    #1;
    checks++;
    if (sb_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL %s gnt: got %b want 1", name, sb_gnt_o);
    end
    @(posedge clk_i); #1;
    sb_req_i   = 1'b0;
    sb_addr_i  = $urandom;
    sb_we_i    = ~we;
    sb_be_i    = ~be;
    sb_wdata_i = $urandom;
    cyc_cnt = 0;
    rv_cnt  = 0;
    rv_at   = -1;
    stable  = 1'b1;
    got_rd  = '0;
    got_err = 1'b0;
    for (int c = 1; c <= TO + 3; c++) begin
      if (wb_cyc_o === 1'b1) begin
        cyc_cnt++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== exp_adr ||
            wb_sel_o !== be || wb_we_o !== we ||
            wb_dat_w_o !== wdata)
          stable = 1'b0;
      end
      if (sb_gnt_o !== 1'b0) stable = 1'b0;
      if (sb_rvalid_o === 1'b1) begin
        rv_cnt++;
        if (rv_at < 0) begin
          rv_at   = c;
          got_rd  = sb_rdata_o;
          got_err = sb_err_o;
        end
      end
      if (wb_cyc_o === 1'b1 && c - 1 == wait_n) begin
        wb_ack_i   = (mode != 1);
        wb_err_i   = (mode != 0);
        wb_dat_r_i = sdata;
      end else begin
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_dat_r_i = $urandom;
      end
      @(posedge clk_i); #1;
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    checks++;
    if (cyc_cnt != ncyc) begin
      errors++;
      $display("FAIL %s cyc_len: got %0d want %0d", name, cyc_cnt, ncyc);
    end
    checks++;
    if (rv_at != ncyc + 1) begin
      errors++;
      $display("FAIL %s rvalid_cycle: got %0d want %0d", name, rv_at, ncyc + 1);
    end
    checks++;
    if (rv_cnt != 1) begin
      errors++;
      $display("FAIL %s rvalid_pulses: got %0d want 1", name, rv_cnt);
    end
    checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
    end
    checks++;
    if (got_err !== bad) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, got_err, bad);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL %s bus_stable: got %b want 1", name, stable);
    end
    checks++;
    if (sb_rdata_o !== exp_rd || sb_err_o !== bad) begin
      errors++;
      $display("FAIL %s resp_hold: got %h/%b want %h/%b",
               name, sb_rdata_o, sb_err_o, exp_rd, bad);
    end
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    sb_req_i   = 1'b1;
    sb_addr_i  = 32'h0;
    sb_we_i    = 1'b0;
    sb_be_i    = 4'h0;
    sb_wdata_i = 32'h0;
    wb_dat_r_i = 32'h0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    #2;
    checks++;
    if (sb_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 0", sb_gnt_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, sb_rvalid_o, sb_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {wb_cyc_o, wb_stb_o, wb_we_o, sb_rvalid_o, sb_err_o});
    end
    checks++;
    if (sb_rdata_o !== 32'h0 || wb_adr_o !== 30'h0 ||
        wb_sel_o !== 4'h0 || wb_dat_w_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want zeros",
               sb_rdata_o, wb_adr_o, wb_sel_o, wb_dat_w_o);
    end
    checks++;
    if (sb_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt_held: got %b want 0", sb_gnt_o);
    end
    sb_req_i = 1'b0;
    rst_i    = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_read_zero_wait();
    run_txn(32'h2000_0010, 1'b0, 4'hF, 32'h0,
            32'hCAFE_F00D, 0, 0, "read0");
  endtask

  task automatic test_write_wait3();
    run_txn(32'h1000_0000, 1'b1, 4'b0011, 32'h1234_5678,
            32'h5555_AAAA, 3, 0, "write3");
  endtask

  task automatic test_error();
    run_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0,
            32'h1111_2222, 1, 2, "err_both");
    run_txn(32'h0000_4004, 1'b1, 4'hC, 32'hA5A5_0000,
            32'h0, 0, 1, "err_wr");
  endtask

  task automatic test_timeout();
    run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0,
            32'h7777_7777, 50, 0, "timeout");
    run_txn(32'h3000_0004, 1'b0, 4'hF, 32'h0,
            32'h8888_9999, TO - 1, 0, "ack_at_limit");
    wb_ack_i   = 1'b1;
    wb_dat_r_i = 32'hBAD0_BAD0;
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sb_rvalid_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL late_ack: got rvalid %b cyc %b want 0 0",
                 sb_rvalid_o, wb_cyc_o);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1;
    logic [31:0] d2;
    d1 = $urandom;
    d2 = $urandom;
    sb_req_i  = 1'b1;
    sb_we_i   = 1'b0;
    sb_be_i   = 4'hF;
    sb_addr_i = 32'h0000_0100;
    #1;
    checks++;
    if (sb_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gnt0: got %b want 1", sb_gnt_o);
    end
    @(posedge clk_i); #1;
    sb_addr_i  = 32'h0000_0204;
    wb_ack_i   = 1'b1;
    wb_dat_r_i = d1;
    #1;
    checks++;
    if (sb_gnt_o !== 1'b0 || wb_cyc_o !== 1'b1 || wb_adr_o !== 30'h40) begin
      errors++;
      $display("FAIL b2b_c1: got gnt %b cyc %b adr %h want 0 1 40",
               sb_gnt_o, wb_cyc_o, wb_adr_o);
    end
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    #1;
    checks++;
    if (sb_rvalid_o !== 1'b1 || sb_rdata_o !== d1 ||
        sb_gnt_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c2: got rv %b rd %h gnt %b cyc %b want 1 %h 1 0",
               sb_rvalid_o, sb_rdata_o, sb_gnt_o, wb_cyc_o, d1);
    end
    @(posedge clk_i); #1;
    sb_req_i   = 1'b0;
    wb_ack_i   = 1'b1;
    wb_dat_r_i = d2;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 30'h81 || sb_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c3: got cyc %b adr %h rv %b want 1 81 0",
               wb_cyc_o, wb_adr_o, sb_rvalid_o);
    end
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    checks++;
    if (sb_rvalid_o !== 1'b1 || sb_rdata_o !== d2 || sb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c4: got rv %b rd %h err %b want 1 %h 0",
               sb_rvalid_o, sb_rdata_o, sb_err_o, d2);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_in_bus();
    sb_req_i  = 1'b1;
    sb_we_i   = 1'b0;
    sb_be_i   = 4'hF;
    sb_addr_i = 32'h0000_0800;
    #1;
    checks++;
    if (sb_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_gnt: got %b want 1", sb_gnt_o);
    end
    @(posedge clk_i); #1;
    sb_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || sb_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_drop: got cyc %b stb %b rv %b want 0 0 0",
               wb_cyc_o, wb_stb_o, sb_rvalid_o);
    end
    wb_ack_i = 1'b1;
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sb_rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_bus_norv: got %b want 0", sb_rvalid_o);
      end
      @(posedge clk_i); #1;
    end
    run_txn(32'h0000_0800, 1'b0, 4'hF, 32'h0,
            32'h0BAD_CAFE, 2, 0, "after_rst");
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 24; i++) begin
      m = int'($urandom_range(0, 5));
      run_txn($urandom, 1'($urandom), 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 10)), (m < 4) ? 0 : m - 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_in_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
